// File: rtl/orbus_rdmux_reg.sv
// Registered read-data OR-bus merging NCH sources into one MDR bus,
// with per-channel masking and sticky multi-driver collision tracking.
module orbus_rdmux_reg #(
  parameter int DW     = 16,
  parameter int NCH    = 6,
  parameter bit STRICT = 1'b1,
  parameter bit HOLD   = 1'b0,
  parameter int CW     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NCH*DW-1:0] MDR_IN,
  input  logic [NCH-1:0]    RDVLD,
  input  logic [NCH-1:0]    CHMASK,
  input  logic              CLR_COLL,
  output logic [DW-1:0]     MDR_OUT,
  output logic              MDR_VLD,
  output logic              COLL,
  output logic [NCH-1:0]    COLL_CH,
  output logic [CW-1:0]     COLL_CNT
);

  localparam logic [CW-1:0]  CNT_MAX = '1;
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [NCH-1:0] EV_ONE  = NCH'(1);

  logic [NCH-1:0] ev;
  logic [DW-1:0]  d_vld;
  logic [DW-1:0]  d_raw;
  logic [DW-1:0]  d_nxt;
  logic           hit;
  logic           coll_c;

  always_comb begin
    ev    = RDVLD & ~CHMASK;
    d_vld = '0;
    d_raw = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ev[k])
        d_vld = d_vld | MDR_IN[k*DW +: DW];
      if (!CHMASK[k])
        d_raw = d_raw | MDR_IN[k*DW +: DW];
    end
    hit = |ev;
    // clearing the lowest set bit leaves something iff >=2 bits set
    coll_c = |(ev & (ev - EV_ONE));
    d_nxt  = '0;
    if (!STRICT)
      d_nxt = d_raw;
    else if (hit)
      d_nxt = d_vld;
    else if (HOLD)
      d_nxt = MDR_OUT;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      MDR_OUT  <= '0;
      MDR_VLD  <= 1'b0;
      COLL     <= 1'b0;
      COLL_CH  <= '0;
      COLL_CNT <= '0;
    end else begin
      MDR_OUT <= d_nxt;
      MDR_VLD <= hit;
      COLL    <= coll_c;
      if (CLR_COLL) begin
        COLL_CH  <= coll_c ? ev : '0;
        COLL_CNT <= coll_c ? CNT_ONE : '0;
      end else if (coll_c) begin
        COLL_CH <= COLL_CH | ev;
        if (COLL_CNT != CNT_MAX)
          COLL_CNT <= COLL_CNT + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_orbus_rdmux_reg.sv
// Bench for orbus_rdmux_reg: three configurations share one stimulus
// (default, HOLD=1, STRICT=0) and are checked against a channel-level model.
module tb_orbus_rdmux_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] mdr_in;
  logic [5:0]  rdvld;
  logic [5:0]  chmask;
  logic        clr;

  logic [15:0] out_q  [3];
  logic        vld_q  [3];
  logic        coll_q [3];
  logic [5:0]  ch_q   [3];
  logic [7:0]  cnt_q  [3];

  logic [15:0] m_out [3];
  logic        m_vld;
  logic        m_coll;
  logic [5:0]  m_ch;
  int          m_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  orbus_rdmux_reg #(.STRICT(1'b1), .HOLD(1'b0)) u_def (
    .CLK(clk), .RESET(rst), .MDR_IN(mdr_in), .RDVLD(rdvld),
    .CHMASK(chmask), .CLR_COLL(clr), .MDR_OUT(out_q[0]),
    .MDR_VLD(vld_q[0]), .COLL(coll_q[0]), .COLL_CH(ch_q[0]),
    .COLL_CNT(cnt_q[0])
  );

  orbus_rdmux_reg #(.STRICT(1'b1), .HOLD(1'b1)) u_hold (
    .CLK(clk), .RESET(rst), .MDR_IN(mdr_in), .RDVLD(rdvld),
    .CHMASK(chmask), .CLR_COLL(clr), .MDR_OUT(out_q[1]),
    .MDR_VLD(vld_q[1]), .COLL(coll_q[1]), .COLL_CH(ch_q[1]),
    .COLL_CNT(cnt_q[1])
  );

  orbus_rdmux_reg #(.STRICT(1'b0), .HOLD(1'b0)) u_raw (
    .CLK(clk), .RESET(rst), .MDR_IN(mdr_in), .RDVLD(rdvld),
    .CHMASK(chmask), .CLR_COLL(clr), .MDR_OUT(out_q[2]),
    .MDR_VLD(vld_q[2]), .COLL(coll_q[2]), .COLL_CH(ch_q[2]),
    .COLL_CNT(cnt_q[2])
  );

  // Channel-level reference: count valid unmasked sources, OR their data.
  task automatic model_edge();
    int          n;
    logic [5:0]  e;
    logic [15:0] ds;
    logic [15:0] dr;
    logic [15:0] c;
    n  = 0;
    e  = '0;
    ds = '0;
    dr = '0;
    for (int k = 0; k < 6; k++) begin
      c = mdr_in[k*16 +: 16];
      if (!chmask[k]) begin
        dr = dr | c;
        if (rdvld[k]) begin
          n++;
          e[k] = 1'b1;
          ds = ds | c;
        end
      end
    end
    if (rst) begin
      for (int i = 0; i < 3; i++) m_out[i] = '0;
      m_vld  = 1'b0;
      m_coll = 1'b0;
      m_ch   = '0;
      m_cnt  = 0;
    end else begin
      m_out[0] = (n > 0) ? ds : 16'h0;
      m_out[1] = (n > 0) ? ds : m_out[1];
      m_out[2] = dr;
      m_vld  = (n > 0);
      m_coll = (n >= 2);
      if (clr) begin
        m_ch  = (n >= 2) ? e : 6'h0;
        m_cnt = (n >= 2) ? 1 : 0;
      end else if (n >= 2) begin
        m_ch = m_ch | e;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst    = 1'b0;
    mdr_in = '0;
    rdvld  = '0;
    chmask = '0;
    clr    = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    rdvld  = 6'h3F;
    mdr_in = '1;
    chmask = '0;
    clr    = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_q[i] !== 16'h0 || vld_q[i] !== 1'b0 || coll_q[i] !== 1'b0 ||
          ch_q[i] !== 6'h0 || cnt_q[i] !== 8'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d: out=%h vld=%b coll=%b ch=%b cnt=%h required all 0",
                 i, out_q[i], vld_q[i], coll_q[i], ch_q[i], cnt_q[i]);
      end
    end
  endtask

  task automatic test_single();
    idle_inputs();
    mdr_in[2*16 +: 16] = 16'hA5A5;
    rdvld = 6'b000100;
    step();
    n_checks++;
    if (out_q[0] !== 16'hA5A5 || vld_q[0] !== 1'b1 || coll_q[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single: out=%h vld=%b coll=%b required a5a5 1 0",
               out_q[0], vld_q[0], coll_q[0]);
    end
    idle_inputs();
    step();
    n_checks++;
    if (out_q[0] !== 16'h0 || vld_q[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: out=%h vld=%b required 0000 0",
               out_q[0], vld_q[0]);
    end
  endtask

  task automatic test_mask();
    idle_inputs();
    mdr_in[0 +: 16]    = 16'h1234;
    mdr_in[5*16 +: 16] = 16'h00F0;
    rdvld  = 6'b100001;
    chmask = 6'b000001;
    step();
    n_checks++;
    if (out_q[0] !== 16'h00F0 || vld_q[0] !== 1'b1 ||
        coll_q[0] !== 1'b0 || ch_q[0] !== 6'h0) begin
      n_fail++;
      $display("FAIL mask: out=%h vld=%b coll=%b ch=%b required 00f0 1 0 000000",
               out_q[0], vld_q[0], coll_q[0], ch_q[0]);
    end
    chmask = 6'h3F;
    step();
    n_checks++;
    if (vld_q[0] !== 1'b0 || coll_q[0] !== 1'b0 || out_q[0] !== 16'h0) begin
      n_fail++;
      $display("FAIL all_masked: out=%h vld=%b coll=%b required 0000 0 0",
               out_q[0], vld_q[0], coll_q[0]);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    mdr_in[1*16 +: 16] = 16'h0F00;
    mdr_in[3*16 +: 16] = 16'h000F;
    rdvld = 6'b001010;
    step();
    n_checks++;
    if (out_q[0] !== 16'h0F0F || coll_q[0] !== 1'b1 ||
        ch_q[0] !== 6'b001010 || cnt_q[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL coll: out=%h coll=%b ch=%b cnt=%h required 0f0f 1 001010 01",
               out_q[0], coll_q[0], ch_q[0], cnt_q[0]);
    end
    for (int j = 0; j < 300; j++) step();
    n_checks++;
    if (cnt_q[0] !== 8'hFF) begin
      n_fail++;
      $display("FAIL coll_sat: cnt=%h required ff", cnt_q[0]);
    end
    clr = 1'b1;
    step();
    n_checks++;
    if (cnt_q[0] !== 8'd1 || ch_q[0] !== 6'b001010 || coll_q[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_with_coll: cnt=%h ch=%b coll=%b required 01 001010 1",
               cnt_q[0], ch_q[0], coll_q[0]);
    end
    rdvld = 6'b000010;
    step();
    n_checks++;
    if (cnt_q[0] !== 8'd0 || ch_q[0] !== 6'h0 || coll_q[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_no_coll: cnt=%h ch=%b coll=%b required 00 000000 0",
               cnt_q[0], ch_q[0], coll_q[0]);
    end
  endtask

  task automatic test_hold();
    idle_inputs();
    mdr_in[4*16 +: 16] = 16'hBEEF;
    rdvld = 6'b010000;
    step();
    rdvld = '0;
    for (int j = 0; j < 5; j++) begin
      step();
      n_checks++;
      if (out_q[1] !== 16'hBEEF || vld_q[1] !== 1'b0 || out_q[0] !== 16'h0) begin
        n_fail++;
        $display("FAIL hold cyc%0d: hold_out=%h vld=%b def_out=%h required beef 0 0000",
                 j, out_q[1], vld_q[1], out_q[0]);
      end
    end
  endtask

  task automatic test_raw_or();
    idle_inputs();
    mdr_in[1*16 +: 16] = 16'h8001;
    step();
    n_checks++;
    if (out_q[2] !== 16'h8001 || vld_q[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_or: out=%h vld=%b required 8001 0",
               out_q[2], vld_q[2]);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 600; j++) begin
      for (int k = 0; k < 6; k++)
        mdr_in[k*16 +: 16] = 16'($urandom);
      rdvld  = 6'($urandom & $urandom);
      chmask = 6'($urandom & $urandom);
      clr    = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 40) == 0);
      step();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (out_q[i] !== m_out[i] || vld_q[i] !== m_vld ||
            coll_q[i] !== m_coll || ch_q[i] !== m_ch ||
            cnt_q[i] !== 8'(m_cnt)) begin
          n_fail++;
          $display("FAIL rand%0d dut%0d: out=%h vld=%b coll=%b ch=%b cnt=%h required %h %b %b %b %h",
                   j, i, out_q[i], vld_q[i], coll_q[i], ch_q[i], cnt_q[i],
                   m_out[i], m_vld, m_coll, m_ch, 8'(m_cnt));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m_out[i] = '0;
    m_vld  = 1'b0;
    m_coll = 1'b0;
    m_ch   = '0;
    m_cnt  = 0;
    idle_inputs();
    #2;
    test_reset();
    test_single();
    test_mask();
    test_collision();
    test_hold();
    test_raw_or();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
